univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal shift register with complementary outputs: the next generation of the single-bit D flip-flop (Q/QBar), generalised to WIDTH bits with hold, parallel load, shift, rotate, arithmetic shift and clear modes. It adds an autonomous burst engine that applies one shift/rotate mode N times under a busy/done handshake. It serves as the storage and serialisation primitive in the course datapath experiments.

## Interface
- WIDTH, 8: register width; legal range WIDTH >= 2.
- CNT_W, 4: width of the burst_len field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  enables a manual command this cycle.
- mode  in  3  operation: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR.
- d  in  WIDTH  parallel load data.
- sin_r  in  1  serial input entering bit 0 on SHL.
- sin_l  in  1  serial input entering bit WIDTH-1 on SHR.
- burst_start  in  1  requests a burst using the current mode and burst_len.
- burst_len  in  CNT_W  number of burst steps.
- q  out  WIDTH  register contents.
- q_bar  out  WIDTH  bitwise complement of q, always.
- shift_out  out  1  bit expelled by the most recent shift or rotate.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse marking burst completion.

## Operation
- Reset values: q=0, q_bar=all ones, shift_out=0, busy=0, done=0, FSM=IDLE. All take effect immediately, without waiting for clk.
- Mode effects on the new q:
  - HOLD: q unchanged.
  - LOAD: q=d.
  - SHL: {q[W-2:0],sin_r}.
  - SHR: {sin_l,q[W-1:1]}.
  - ROL: {q[W-2:0],q[W-1]}.
  - ROR: {q[0],q[W-1:1]}.
  - ASR: {q[W-1],q[W-1:1]}.
  - CLR: q=0.
- shift_out: SHL and ROL load the old q[W-1]. SHR, ROR and ASR load the old q[0]. HOLD, LOAD and CLR leave shift_out unchanged.
- FSM states IDLE and BURST.
- In IDLE:
  - burst_start=1 with mode in {SHL,SHR,ROL,ROR,ASR} and burst_len>0: latch mode, burst_len, sin_l and sin_r; busy=1; go to BURST. No q change on this edge.
  - burst_start=1 with burst_len=0 and a shift mode: done=1 for the next cycle only; busy stays 0; q unchanged.
  - burst_start=1 with HOLD, LOAD or CLR: the request is ignored entirely (no done) and no manual command executes.
  - burst_start=0 and en=1: apply mode once.
  - burst_start takes priority over en in the same cycle.
- In BURST:
  - Each edge applies the latched mode using the latched serial inputs, then decrements the count.
  - On the edge applying the last step: busy falls to 0, done=1 for one cycle, return to IDLE.
  - en, mode, d and burst_start are ignored for the whole burst.
- burst_len may exceed WIDTH; rotates wrap naturally.
- rst during BURST aborts the burst: reset values apply and no done is ever produced for it.

## Timing
- Manual op: result visible on q and q_bar after the sampling edge (latency 1).
- Burst of N steps:
  - Sampling edge k sets busy.
  - Shifts occur on edges k+1 through k+N.
  - busy is high for exactly N cycles.
  - done is high in the cycle after edge k+N, coincident with busy=0.
- Back-to-back bursts: a new burst_start is accepted in the cycle in which done is high.
- q_bar is combinational from q; there is no extra latency.
- shift_out is registered and updates on the same edge as q.

## Structure
- Package usr_pkg holds:
  - Mode encodings (MODE_HOLD..MODE_CLR).
  - FSM state constants (ST_IDLE, ST_BURST).
  - Helper function is_shift_mode().
- Sub-module usr_shift_unit: purely combinational. Computes the next q and the expelled bit from (q, mode, sin_l, sin_r). It is shared by the manual and burst paths.
- The top level holds the registers, the FSM and the down-counter.

## Test plan
All cases use WIDTH=8, CNT_W=4.
- Reset: pulse rst between clock edges → q=00 and q_bar=FF immediately; busy=0, done=0.
- Load/hold/enable:
  - LOAD d=A5 with en=1 → q=A5, q_bar=5A.
  - Then en=0 with LOAD d=FF → q stays A5.
  - Then HOLD → q stays A5.
- Shifts:
  - SHL sin_r=1 on A5 → q=4B, shift_out=1.
  - SHR sin_l=0 on 4B → q=25, shift_out=1.
  - ASR on 80 → q=C0, shift_out=0.
  - CLR → q=00, shift_out unchanged.
- Burst:
  - q=81, ROL with burst_len=3 → busy high for 3 cycles; q steps 03, 06, 0C.
  - done pulses once, coincident with busy falling.
  - en=1 with LOAD during the burst → no effect.
- Burst edge cases:
  - burst_len=0 → done the next cycle, busy never rises, q unchanged.
  - burst_start with LOAD mode → ignored, no done.
  - burst_start while busy → ignored.
- Reset mid-burst: SHR burst with burst_len=5, rst asserted at step 2 → q=00 and busy=0 immediately; done never asserts. A fresh burst is accepted after rst is released.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings,
// burst FSM states and a mode-classification helper.
package usr_pkg;

    // Operation encodings carried on the 3-bit mode input.
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Burst engine states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // True for the modes a burst may repeat (all shifts and rotates).
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational next-state logic for the shift register: given the current
// contents, an operation and the serial inputs, produce the new contents and
// the bit expelled by a shift or rotate. Shared by manual and burst paths.
module usr_shift_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out,
    output logic             bit_upd
);

    // Decode the operation into new contents and the expelled bit.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        q_next  = q;
        bit_out = 1'b0;
        bit_upd = 1'b0;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = q;
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], sin_r};
                bit_out = q[WIDTH-1];
                bit_upd = 1'b1;
            end
            MODE_SHR: begin
                q_next  = {sin_l, q[WIDTH-1:1]};
                bit_out = q[0];
                bit_upd = 1'b1;
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
                bit_upd = 1'b1;
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
                bit_upd = 1'b1;
            end
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                bit_out = q[0];
                bit_upd = 1'b1;
            end
            MODE_CLR: q_next = '0;
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with complementary outputs and an autonomous
// burst engine that repeats one shift/rotate mode burst_len times under a
// busy/done handshake. Parallel load data is muxed in here; all other
// operations come from the shared shift unit.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       b_mode;
    logic             b_sin_l;
    logic             b_sin_r;

    logic [2:0]       op_mode;
    logic             op_sin_l;
    logic             op_sin_r;
    logic [WIDTH-1:0] shift_q;
    logic             shift_bit;
    logic             shift_upd;
    logic [WIDTH-1:0] manual_q;

    // During a burst the shift unit runs from the latched command, so the
    // live inputs cannot disturb it.
    always_comb begin
        op_mode  = mode;
        op_sin_l = sin_l;
        op_sin_r = sin_r;
        if (state == ST_BURST) begin
            op_mode  = b_mode;
            op_sin_l = b_sin_l;
            op_sin_r = b_sin_r;
        end
    end

    usr_shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .q       (q),
        .mode    (op_mode),
        .sin_l   (op_sin_l),
        .sin_r   (op_sin_r),
        .q_next  (shift_q),
        .bit_out (shift_bit),
        .bit_upd (shift_upd)
    );

    // Manual path: parallel load bypasses the shift unit.
    assign manual_q = (mode == MODE_LOAD) ? d : shift_q;

    // The complement tracks q combinationally with no extra register.
    assign q_bar = ~q;

    // Register file plus burst FSM: manual commands in IDLE, repeated steps
    // in BURST, one-cycle done pulse on completion or zero-length request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            q         <= '0;
            shift_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            b_mode    <= MODE_HOLD;
            b_sin_l   <= 1'b0;
            b_sin_r   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register sees pre-edge values, matching real flip-flop behaviour.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (burst_start) begin
                        // Non-shift modes make the whole request a no-op.
                        if (is_shift_mode(mode)) begin
                            if (burst_len != '0) begin
                                b_mode  <= mode;
                                b_sin_l <= sin_l;
                                b_sin_r <= sin_r;
                                cnt     <= burst_len;
                                busy    <= 1'b1;
                                state   <= ST_BURST;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end else if (en) begin
                        q <= manual_q;
                        if (shift_upd) begin
                            shift_out <= shift_bit;
                        end
                    end
                end
                ST_BURST: begin
                    q         <= shift_q;
                    shift_out <= shift_bit;
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
